// File: rtl/frame_checksum.sv
// frame_checksum
// Frame-oriented checksum engine. Beats arrive over in_valid/in_ready and are
// accumulated under one of four modes, which is latched on the first beat of each
// frame. The finished checksum and the saturating beat count are held on
// out_sum/out_len while out_valid is high, until the consumer takes them with
// out_ready.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   mode      - 0 LRC, 1 XOR, 2 Fletcher-style dual sum, 3 plain sum
//   abort     - synchronous frame discard; wins over accept and out_ready
//   in_data   - data beat (DATA_W bits)
//   in_valid  - in_data valid
//   in_last   - beat closes the frame
//   in_ready  - engine can accept a beat (IDLE / ACCUM)
//   out_sum   - checksum result, 2*DATA_W bits
//   out_len   - accepted beats in the frame, saturating at all-ones
//   out_valid - result valid (DONE)
//   out_ready - consumer takes the result
module frame_checksum #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [2*DATA_W-1:0]   out_sum,
    output logic [LEN_W-1:0]      out_len,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_MAX  = {LEN_W{1'b1}};

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   s1_reg, s1_next;
    logic [DATA_W-1:0]   s2_reg, s2_next;
    logic [LEN_W-1:0]    len_reg, len_next;
    logic [1:0]          mode_reg, mode_next;

    // Working values for the beat being accepted. A frame's first beat starts
    // from zero and uses the live mode input; later beats use the latched state.
    logic [1:0]          eff_mode;
    logic [DATA_W-1:0]   base_s1, base_s2, upd_s1, upd_s2;
    logic [LEN_W-1:0]    upd_len;
    logic                accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            s1_reg    <= '0;
            s2_reg    <= '0;
            len_reg   <= '0;
            mode_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            s1_reg    <= s1_next;
            s2_reg    <= s2_next;
            len_reg   <= len_next;
            mode_reg  <= mode_next;
        end
    end

    assign in_ready = (state_reg != DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        eff_mode = (state_reg == IDLE) ? mode : mode_reg;
        base_s1  = (state_reg == IDLE) ? '0 : s1_reg;
        base_s2  = (state_reg == IDLE) ? '0 : s2_reg;
        upd_s1   = base_s1 + in_data;
        upd_s2   = base_s2;
        case (eff_mode)
            2'd1:    upd_s1 = base_s1 ^ in_data;
            2'd2:    upd_s2 = base_s2 + upd_s1;
            default: ;
        endcase
        if (state_reg == IDLE) begin
            upd_len = LEN_ONE;
        end else begin
            upd_len = (len_reg == LEN_MAX) ? len_reg : len_reg + LEN_ONE;
        end
    end

    always_comb begin
        state_next = state_reg;
        s1_next    = s1_reg;
        s2_next    = s2_reg;
        len_next   = len_reg;
        mode_next  = mode_reg;
        if (abort) begin
            state_next = IDLE;
            s1_next    = '0;
            s2_next    = '0;
            len_next   = '0;
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    if (accept) begin
                        mode_next  = eff_mode;
                        s1_next    = upd_s1;
                        s2_next    = upd_s2;
                        len_next   = upd_len;
                        state_next = in_last ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                        s1_next    = '0;
                        s2_next    = '0;
                        len_next   = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are zero outside DONE so nothing half-accumulated is ever visible.
    always_comb begin
        out_valid = (state_reg == DONE);
        out_sum   = '0;
        out_len   = '0;
        if (out_valid) begin
            out_len = len_reg;
            case (mode_reg)
                2'd0:    out_sum = {{DATA_W{1'b0}}, (~s1_reg) + DATA_ONE};
                2'd2:    out_sum = {s2_reg, s1_reg};
                default: out_sum = {{DATA_W{1'b0}}, s1_reg};
            endcase
        end
    end

endmodule
